// File: rtl/memory_access_pkg.sv
// Shared encodings for the LEGv8 memory-access stage: word width, FSM states,
// fault codes and the data-memory request payload.
package memory_access_pkg;

  localparam int unsigned WORD       = 64;
  localparam int unsigned ALIGN_BITS = 3;

  localparam logic [1:0] FAULT_NONE     = 2'd0;
  localparam logic [1:0] FAULT_MISALIGN = 2'd1;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'd2;
  localparam logic [1:0] FAULT_CONFLICT = 2'd3;

  typedef enum logic [1:0] {
    MEM_IDLE   = 2'd0,
    MEM_ACCESS = 2'd1,
    MEM_DONE   = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic            we;
    logic [WORD-1:0] addr;
    logic [WORD-1:0] wdata;
  } dmem_req_t;

  // Doubleword accesses must sit on an 8-byte boundary.
  function automatic logic is_aligned(input logic [WORD-1:0] addr);
    return addr[ALIGN_BITS-1:0] == '0;
  endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Wait-cycle counter for a memory request; expired_c fires on the enabled
// cycle that would make the count reach LIMIT.
module mem_timeout_counter #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count;

  // Saturates at LIMIT so a stuck enable cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CNT_W'(LIMIT))) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired_c = enable && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/memory_access.sv
// LEGv8 memory-access stage: one data-memory transaction per instruction over
// req/ack, branch resolution, front-end stall and fault reporting.
module memory_access
  import memory_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [WORD-1:0] alu_result,
  input  logic [WORD-1:0] write_data,
  input  logic [WORD-1:0] branch_target,
  input  logic            zero,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            branch,
  input  logic            uncond_branch,
  output logic            busy,
  output logic            done,
  output logic [WORD-1:0] read_data,
  output logic            pc_src,
  output logic [WORD-1:0] pc_target,
  output logic            fault,
  output logic [1:0]      fault_code,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [WORD-1:0] dmem_addr,
  output logic [WORD-1:0] dmem_wdata,
  input  logic [WORD-1:0] dmem_rdata,
  input  logic            dmem_ack
);

  mem_state_t      state, state_d;
  dmem_req_t       req_q, req_d;
  logic            load_q, load_d;
  logic            pc_src_d, fault_d;
  logic [1:0]      fault_code_d;
  logic [WORD-1:0] read_data_d, pc_target_d;
  logic            cnt_clear_c, cnt_enable_c, expired_c;
  logic            mem_op_c;

  assign mem_op_c = mem_read | mem_write;

  mem_timeout_counter #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (cnt_clear_c),
    .enable    (cnt_enable_c),
    .expired_c (expired_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MEM_IDLE;
    else        state <= state_d;
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_d      = state;
    req_d        = req_q;
    load_d       = load_q;
    pc_src_d     = pc_src;
    pc_target_d  = pc_target;
    fault_d      = fault;
    fault_code_d = fault_code;
    read_data_d  = read_data;
    cnt_clear_c  = 1'b0;
    cnt_enable_c = 1'b0;

    case (state)
      MEM_IDLE: begin
        if (start) begin
          pc_src_d     = uncond_branch | (branch & zero);
          pc_target_d  = branch_target;
          fault_d      = 1'b0;
          fault_code_d = FAULT_NONE;
          req_d.we     = mem_write;
          req_d.addr   = alu_result;
          req_d.wdata  = write_data;
          load_d       = mem_read;
          cnt_clear_c  = 1'b1;
          if (mem_read && mem_write) begin
            fault_d      = 1'b1;
            fault_code_d = FAULT_CONFLICT;
            state_d      = MEM_DONE;
          end else if (mem_op_c && !is_aligned(alu_result)) begin
            fault_d      = 1'b1;
            fault_code_d = FAULT_MISALIGN;
            state_d      = MEM_DONE;
          end else if (mem_op_c) begin
            state_d = MEM_ACCESS;
          end else begin
            state_d = MEM_DONE;
          end
        end
      end
      MEM_ACCESS: begin
        cnt_enable_c = !dmem_ack;
        // An ack on the expiry edge still completes the access cleanly.
        if (dmem_ack) begin
          if (load_q) read_data_d = dmem_rdata;
          state_d = MEM_DONE;
        end else if (expired_c) begin
          fault_d      = 1'b1;
          fault_code_d = FAULT_TIMEOUT;
          state_d      = MEM_DONE;
        end
      end
      MEM_DONE: state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      req_q      <= '0;
      load_q     <= 1'b0;
      read_data  <= '0;
      pc_src     <= 1'b0;
      pc_target  <= '0;
      fault      <= 1'b0;
      fault_code <= FAULT_NONE;
    end else begin
      busy       <= (state_d != MEM_IDLE);
      done       <= (state_d == MEM_DONE);
      dmem_req   <= (state_d == MEM_ACCESS);
      dmem_we    <= (state_d == MEM_ACCESS) && req_d.we;
      req_q      <= req_d;
      load_q     <= load_d;
      read_data  <= read_data_d;
      pc_src     <= pc_src_d;
      pc_target  <= pc_target_d;
      fault      <= fault_d;
      fault_code <= fault_code_d;
    end
  end

  assign dmem_addr  = req_q.addr;
  assign dmem_wdata = req_q.wdata;

endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: the driver queues expected retire and
// bus records, separate monitors pop and compare them as the DUT presents them.
module tb_memory_access;

  localparam int unsigned W = 64;
  localparam int NEVER = 1000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] alu_result = '0, write_data = '0, branch_target = '0;
  logic         zero = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic         branch = 1'b0, uncond_branch = 1'b0;
  logic         busy, done, pc_src, fault, dmem_req, dmem_we;
  logic [W-1:0] read_data, pc_target, dmem_addr, dmem_wdata;
  logic [1:0]   fault_code;
  logic [W-1:0] dmem_rdata = '0;
  logic         dmem_ack = 1'b0;

  memory_access #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_result(alu_result),
    .write_data(write_data), .branch_target(branch_target), .zero(zero),
    .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
    .uncond_branch(uncond_branch), .busy(busy), .done(done),
    .read_data(read_data), .pc_src(pc_src), .pc_target(pc_target),
    .fault(fault), .fault_code(fault_code), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [W-1:0] rd;
    logic         pc_src;
    logic [W-1:0] tgt;
    logic         fault;
    logic [1:0]   code;
  } ret_t;

  typedef struct {
    logic         we;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    int           len;
  } bus_t;

  ret_t ret_q[$];
  bus_t bus_q[$];
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0;
  int   ack_after = NEVER;
  int   req_cnt = 0;
  bus_t cur_bus;
  logic [W-1:0] exp_rd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Retire monitor.
  always @(negedge clk) begin
    ret_t e;
    if (rst_n && done) begin
      if (ret_q.size() == 0) begin
        chk("unexpected_done", 64'(1), 64'(0));
      end else begin
        e = ret_q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk("read_data", read_data, e.rd);
        chk("pc_src", 64'(pc_src), 64'(e.pc_src));
        chk("pc_target", pc_target, e.tgt);
        chk("fault", 64'(fault), 64'(e.fault));
        chk("fault_code", 64'(fault_code), 64'(e.code));
      end
    end
  end

  // Memory responder and bus monitor.
  always @(negedge clk) begin
    if (dmem_req) begin
      req_cnt++;
      if (req_cnt == 1) begin
        if (bus_q.size() == 0) begin
          chk("unexpected_req", 64'(1), 64'(0));
          cur_bus = '{we: 1'b0, addr: '0, wdata: '0, len: 0};
        end else begin
          cur_bus = bus_q.pop_front();
          chk("dmem_we", 64'(dmem_we), 64'(cur_bus.we));
          chk("dmem_addr", dmem_addr, cur_bus.addr);
          if (cur_bus.we) chk("dmem_wdata", dmem_wdata, cur_bus.wdata);
        end
      end
      dmem_ack = (req_cnt == ack_after + 1);
    end else begin
      if (req_cnt > 0) chk("req_cycles", 64'(req_cnt), 64'(cur_bus.len));
      req_cnt  = 0;
      dmem_ack = 1'b0;
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (busy) chk("idle_timeout", 64'(busy), 64'(0));
  endtask

  task automatic issue(input logic rd, input logic wr, input logic br, input logic ub,
                       input logic z, input logic [W-1:0] addr, input logic [W-1:0] wd,
                       input logic [W-1:0] tgt, input logic [W-1:0] rdata,
                       input int ack_n, input int lat, input int req_len,
                       input logic exp_pc, input logic exp_fault, input logic [1:0] exp_code);
    @(negedge clk);
    wait_idle();
    mem_read = rd; mem_write = wr; branch = br; uncond_branch = ub; zero = z;
    alu_result = addr; write_data = wd; branch_target = tgt;
    dmem_rdata = rdata; ack_after = ack_n;
    if (rd && !wr && exp_code == 2'd0) exp_rd = rdata;
    ret_q.push_back('{cyc: cyc + lat, rd: exp_rd, pc_src: exp_pc, tgt: tgt,
                      fault: exp_fault, code: exp_code});
    if (req_len > 0) bus_q.push_back('{we: wr, addr: addr, wdata: wd, len: req_len});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_req"}, 64'(dmem_req), 64'(0));
    chk({tag, "_we"}, 64'(dmem_we), 64'(0));
    chk({tag, "_read_data"}, read_data, 64'(0));
    chk({tag, "_pc_src"}, 64'(pc_src), 64'(0));
    chk({tag, "_pc_target"}, pc_target, 64'(0));
    chk({tag, "_fault_code"}, 64'({fault, fault_code}), 64'(0));
  endtask

  initial begin
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // LDUR 80, three wait cycles then ack on the fourth request cycle.
    issue(1,0,0,0,0, 64'd80, 64'd0, 64'd0, 64'hDEADBEEF, 3, 5, 4, 0, 0, 2'd0);
    // STUR 112, zero-wait ack; read_data stays 0xDEADBEEF.
    issue(0,1,0,0,0, 64'd112, 64'd0, 64'd0, 64'h1111, 0, 2, 1, 0, 0, 2'd0);
    // ADD, CBZ taken, B with zero=0, CBZ not taken.
    issue(0,0,0,0,0, 64'd30, 64'd0, 64'd0, 64'd0, NEVER, 1, 0, 0, 0, 2'd0);
    issue(0,0,1,0,1, 64'd0, 64'd0, 64'd196, 64'd0, NEVER, 1, 0, 1, 0, 2'd0);
    issue(0,0,0,1,0, 64'd8, 64'd0, 64'd400, 64'd0, NEVER, 1, 0, 1, 0, 2'd0);
    issue(0,0,1,0,0, 64'd8, 64'd0, 64'd500, 64'd0, NEVER, 1, 0, 0, 0, 2'd0);
    // Misaligned load, aligned conflict, misaligned conflict (conflict wins).
    issue(1,0,0,0,0, 64'h54, 64'd0, 64'd0, 64'h77, 0, 1, 0, 0, 1, 2'd1);
    issue(1,1,0,0,0, 64'h60, 64'd5, 64'd0, 64'h77, 0, 1, 0, 0, 1, 2'd3);
    issue(1,1,0,0,0, 64'h61, 64'd5, 64'd0, 64'h77, 0, 1, 0, 0, 1, 2'd3);
    // Timeout with no ack; then ack exactly on the expiry cycle.
    issue(1,0,0,0,0, 64'h100, 64'd0, 64'd0, 64'h99, NEVER, 5, 4, 0, 1, 2'd2);
    issue(1,0,0,0,0, 64'h108, 64'd0, 64'd0, 64'h1234, 3, 5, 4, 0, 0, 2'd0);
    // Store with two wait cycles.
    issue(0,1,0,0,0, 64'h200, 64'hCAFE, 64'd0, 64'd0, 2, 4, 3, 0, 0, 2'd0);

    // Reset in the middle of a load: request drops at once, no retire.
    @(negedge clk);
    mem_read = 1; mem_write = 0; branch = 0; uncond_branch = 0;
    alu_result = 64'h300; branch_target = 64'h44; ack_after = NEVER;
    bus_q.push_back('{we: 1'b0, addr: 64'h300, wdata: 64'd0, len: 2});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    exp_rd = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // start held high across DONE: accepted, ignored in DONE, accepted again.
    @(negedge clk);
    mem_read = 0; mem_write = 0; branch = 0; uncond_branch = 1; zero = 0;
    alu_result = 64'd16; branch_target = 64'h600;
    ret_q.push_back('{cyc: cyc + 1, rd: exp_rd, pc_src: 1'b1, tgt: 64'h600, fault: 1'b0, code: 2'd0});
    ret_q.push_back('{cyc: cyc + 3, rd: exp_rd, pc_src: 1'b1, tgt: 64'h600, fault: 1'b0, code: 2'd0});
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Load after reset, zero-wait.
    issue(1,0,0,0,0, 64'd8, 64'd0, 64'd0, 64'h55, 0, 2, 1, 0, 0, 2'd0);

    repeat (3) @(negedge clk);
    chk("ret_q_drained", 64'(ret_q.size()), 64'(0));
    chk("bus_q_drained", 64'(bus_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
